// File: rtl/gf_pkg.sv
// GF(2^8) constants shared by the gf_poly_* / RS blocks: field polynomial,
// alpha-power table and the syndrome FSM state type.
package gf_pkg;

  localparam int GF_M = 8;
  localparam int GF_ORDER = 255;
  localparam logic [GF_M:0] PRIM_POLY = 9'h11D;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    HOLD
  } synd_state_t;

  function automatic logic [GF_M-1:0] gf_xtime(input logic [GF_M-1:0] a);
    return {a[GF_M-2:0], 1'b0} ^ ({GF_M{a[GF_M-1]}} & PRIM_POLY[GF_M-1:0]);
  endfunction

  // alpha^0 .. alpha^(GF_ORDER-1), entry i at bits [i*GF_M +: GF_M]
  function automatic logic [GF_ORDER*GF_M-1:0] gen_alpha_tab();
    logic [GF_ORDER*GF_M-1:0] tab;
    logic [GF_M-1:0] a;
    tab = '0;
    a = 8'h01;
    for (int i = 0; i < GF_ORDER; i++) begin
      tab[i*GF_M +: GF_M] = a;
      a = gf_xtime(a);
    end
    return tab;
  endfunction

  localparam logic [GF_ORDER*GF_M-1:0] ALPHA_TAB = gen_alpha_tab();

  function automatic logic [GF_M-1:0] alpha_pow(input int j);
    return ALPHA_TAB[(j % GF_ORDER)*GF_M +: GF_M];
  endfunction

endpackage

// File: rtl/rs_syndrome_calc_if.sv
// Symbol stream in, flat syndrome vector out, each with valid/ready.
interface rs_syndrome_calc_if #(
  parameter int SIZE = 8,
  parameter int NSYM = 16
);
  logic [SIZE-1:0]      in_sym;
  logic                 in_valid;
  logic                 in_last;
  logic                 in_ready;
  logic [NSYM*SIZE-1:0] flat_synd;
  logic                 synd_valid;
  logic                 synd_ready;
  logic                 err_flag;
  logic                 len_err;

  modport master (
    output in_sym, in_valid, in_last, synd_ready,
    input  in_ready, flat_synd, synd_valid, err_flag, len_err
  );

  modport slave (
    input  in_sym, in_valid, in_last, synd_ready,
    output in_ready, flat_synd, synd_valid, err_flag, len_err
  );
endinterface

// File: rtl/gf_const_mult.sv
// Multiply a GF(2^SIZE) element by the compile-time constant C; the column
// table folds to constants so only an XOR network remains.
module gf_const_mult
  import gf_pkg::*;
#(
  parameter int SIZE = 8,
  parameter logic [SIZE-1:0] C = '0
) (
  input  logic [SIZE-1:0] a,
  output logic [SIZE-1:0] y
);

  function automatic logic [SIZE-1:0] xt(input logic [SIZE-1:0] v);
    return {v[SIZE-2:0], 1'b0} ^ ({SIZE{v[SIZE-1]}} & PRIM_POLY[SIZE-1:0]);
  endfunction

  // column i of the multiplication matrix is C * alpha^i
  always_comb begin
    logic [SIZE-1:0] col;
    y = '0;
    col = C;
    for (int i = 0; i < SIZE; i++) begin
      if (a[i]) y = y ^ col;
      col = xt(col);
    end
  end

endmodule

// File: rtl/rs_syndrome_calc.sv
// Reed-Solomon syndrome calculator: Horner evaluation of S_j = r(alpha^j).
// RS_SYND_LEN_CHECK_EN enables the symbol counter and len_err; otherwise len_err=0.
//
// state | meaning
// IDLE  | waiting for first symbol; a transfer loads every S_j
// ACCUM | accumulating symbols until in_last
// HOLD  | result presented on flat_synd until synd_ready
module rs_syndrome_calc
  import gf_pkg::*;
#(
  parameter int m      = 255,
  parameter int SIZE   = $clog2(m),
  parameter int NSYM   = 16,
  parameter int CW_LEN = 255
) (
  input logic clk,
  input logic rst,
  rs_syndrome_calc_if.slave bus
);

  synd_state_t state, state_nxt;
  logic [SIZE-1:0] synd     [NSYM];
  logic [SIZE-1:0] synd_nxt [NSYM];
  logic [SIZE-1:0] scaled   [NSYM];
  logic xfer, err_nxt, err_flag_q, len_err_q;

  assign xfer = bus.in_valid && (state != HOLD);

  for (genvar j = 0; j < NSYM; j++) begin : g_synd
    gf_const_mult #(.SIZE(SIZE), .C(alpha_pow(j))) u_mult (
      .a(synd[j]),
      .y(scaled[j])
    );
    assign bus.flat_synd[j*SIZE +: SIZE] = synd[j];
  end

  always_comb begin
    state_nxt = state;
    err_nxt = 1'b0;
    for (int j = 0; j < NSYM; j++) begin
      synd_nxt[j] = (state == IDLE) ? bus.in_sym : (scaled[j] ^ bus.in_sym);
      err_nxt = err_nxt | (|synd_nxt[j]);
    end
    case (state)
      IDLE:    if (xfer) state_nxt = bus.in_last ? HOLD : ACCUM;
      ACCUM:   if (xfer && bus.in_last) state_nxt = HOLD;
      HOLD:    if (bus.synd_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      err_flag_q <= 1'b0;
      for (int j = 0; j < NSYM; j++) synd[j] <= '0;
    end else begin
      state <= state_nxt;
      if (xfer) begin
        for (int j = 0; j < NSYM; j++) synd[j] <= synd_nxt[j];
        if (bus.in_last) err_flag_q <= err_nxt;
      end
    end
  end

`ifdef RS_SYND_LEN_CHECK_EN
  localparam int CNT_W = $clog2(CW_LEN) + 1;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  // saturating so an overlong codeword can never wrap back onto CW_LEN
  always_comb begin
    cnt_nxt = cnt;
    if (state == IDLE) cnt_nxt = CNT_W'(1);
    else if (!(&cnt)) cnt_nxt = cnt + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      len_err_q <= 1'b0;
    end else if (xfer) begin
      cnt <= cnt_nxt;
      if (bus.in_last) len_err_q <= (cnt_nxt != CNT_W'(CW_LEN));
    end
  end
`else
  assign len_err_q = 1'b0;
`endif

  assign bus.in_ready   = (state != HOLD);
  assign bus.synd_valid = (state == HOLD);
  assign bus.err_flag   = err_flag_q;
  assign bus.len_err    = len_err_q;

endmodule

// File: tb/tb_rs_syndrome_calc.sv
// Scoreboard bench for rs_syndrome_calc (CW_LEN=7, NSYM=4), hand-computed vectors.
module tb_rs_syndrome_calc;
  localparam int SIZE = 8;
  localparam int NSYM = 4;
  localparam int CW_LEN = 7;
`ifdef RS_SYND_LEN_CHECK_EN
  localparam bit LEN_CHK = 1'b1;
`else
  localparam bit LEN_CHK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rs_syndrome_calc_if #(.SIZE(SIZE), .NSYM(NSYM)) bus ();

  rs_syndrome_calc #(.m(255), .SIZE(SIZE), .NSYM(NSYM), .CW_LEN(CW_LEN)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct packed {
    logic [31:0] synd;
    logic        err;
    logic        len;
  } exp_t;

  exp_t exp_q[$];
  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic push(input logic [31:0] s, input logic e, input logic l);
    exp_t x;
    x.synd = s;
    x.err = e;
    x.len = l;
    exp_q.push_back(x);
  endtask

  // monitor: compare each accepted result against the scoreboard head
  always @(negedge clk) begin
    if (!rst && bus.synd_valid && bus.synd_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_result: got flat_synd %h, expected no result", bus.flat_synd);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("flat_synd", bus.flat_synd, e.synd);
        check("err_flag", bus.err_flag, e.err);
        check("len_err", bus.len_err, e.len);
      end
    end
  end

  // called at posedge+1; returns at posedge+1 after the transfer
  task automatic send_sym(input logic [7:0] s, input logic last);
    int n;
    bus.in_sym = s;
    bus.in_valid = 1'b1;
    bus.in_last = last;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) begin
      n_checks++;
      n_fail++;
      $display("FAIL in_ready_timeout: got in_ready 0 for 50 cycles, expected 1");
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_last = 1'b0;
  endtask

  // codeword of len zero symbols, except symbol index pos which is val
  task automatic send_cw(input int len, input int pos, input logic [7:0] val);
    for (int i = 0; i < len; i++) begin
      if (i == len - 1) check("valid_before_last", bus.synd_valid, 1'b0);
      send_sym((i == pos) ? val : 8'h00, i == len - 1);
    end
    check("valid_latency", bus.synd_valid, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_sym = 8'h00;
    bus.in_last = 1'b0;
    bus.synd_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_flat_synd", bus.flat_synd, 32'h0);
    check("rst_synd_valid", bus.synd_valid, 1'b0);
    check("rst_err_flag", bus.err_flag, 1'b0);
    check("rst_len_err", bus.len_err, 1'b0);
    rst = 1'b0;
    #1;
    check("rst_in_ready", bus.in_ready, 1'b1);
    @(posedge clk); #1;

    push(32'h00000000, 1'b0, 1'b0);
    send_cw(7, -1, 8'h00);
    @(posedge clk); #1;

    push(32'h01010101, 1'b1, 1'b0);
    send_cw(7, 6, 8'h01);
    @(posedge clk); #1;

    push(32'h08040201, 1'b1, 1'b0);
    send_cw(7, 5, 8'h01);
    @(posedge clk); #1;

    push(32'h05050505, 1'b1, LEN_CHK);
    send_cw(3, 2, 8'h05);
    @(posedge clk); #1;

    // 23 beats: a wrapping 4-bit counter would land on 7 and hide the error
    push(32'h01010101, 1'b1, LEN_CHK);
    send_cw(23, 22, 8'h01);
    @(posedge clk); #1;

    // backpressure: S_j = alpha^(6j) -> 01, 40, CD, 2D
    bus.synd_ready = 1'b0;
    push(32'h2DCD4001, 1'b1, 1'b0);
    send_cw(7, 0, 8'h01);
    bus.in_valid = 1'b1;
    bus.in_sym = 8'h01;
    bus.in_last = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("bp_synd_valid", bus.synd_valid, 1'b1);
      check("bp_in_ready", bus.in_ready, 1'b0);
      check("bp_flat_synd", bus.flat_synd, 32'h2DCD4001);
      check("bp_err_flag", bus.err_flag, 1'b1);
      @(posedge clk); #1;
    end
    bus.synd_ready = 1'b1;
    @(posedge clk); #1;
    check("release_in_ready", bus.in_ready, 1'b1);
    check("release_synd_valid", bus.synd_valid, 1'b0);
    push(32'h2DCD4001, 1'b1, 1'b0);
    send_cw(7, 0, 8'h01);
    @(posedge clk); #1;

    // reset mid-codeword discards the partial result
    send_sym(8'h03, 1'b0);
    for (int i = 0; i < 3; i++) send_sym(8'h00, 1'b0);
    rst = 1'b1;
    #1;
    check("midrst_flat_synd", bus.flat_synd, 32'h0);
    check("midrst_synd_valid", bus.synd_valid, 1'b0);
    check("midrst_err_flag", bus.err_flag, 1'b0);
    check("midrst_len_err", bus.len_err, 1'b0);
    check("midrst_in_ready", bus.in_ready, 1'b1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    push(32'h00000000, 1'b0, 1'b0);
    send_cw(7, -1, 8'h00);

    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("scoreboard_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
